// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: register file, Y/Z/HI/LO/PC/MAR/MDR/IR around one shared bus,
// with an integrated ALU, bus-conflict detection and an autonomous instruction-fetch sequencer.
module param_bus_datapath #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter bit                R0_ZERO  = 1'b0,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic [NUM_REGS-1:0] reg_out,
  input  logic                pc_out,
  input  logic                zhigh_out,
  input  logic                zlow_out,
  input  logic                mdr_out,
  input  logic                hi_out,
  input  logic                lo_out,
  input  logic                y_out,
  input  logic                pc_in,
  input  logic                inc_pc,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                ir_in,
  input  logic                y_in,
  input  logic                z_in,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                read,
  input  logic [2:0]          alu_op,
  input  logic                fetch_start,
  output logic                fetch_busy,
  output logic                fetch_done,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   ir_value,
  output logic [DATA_W-1:0]   bus_value,
  output logic                bus_conflict,
  output logic                conflict_sticky
);
  localparam int                NSRC = NUM_REGS + 7;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_T0, S_T1, S_T2} state_e;

  state_e                           state_q, state_d;
  logic                             t1_first_q, t1_first_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DATA_W-1:0]                y_q, y_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]                pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [2*DATA_W-1:0]              z_q, z_d;
  logic                             sticky_q, sticky_d;

  logic                busy, multi;
  logic [NSRC-1:0]     sel;
  logic [DATA_W-1:0]   src_val [NSRC];
  logic [DATA_W-1:0]   ext_bus, fetch_val, bus;
  logic [DATA_W:0]     add_w, sub_w;
  logic [2*DATA_W-1:0] mul_w, alu_z;

  assign busy = (state_q != S_IDLE);

  // Sources ordered: R0..Rn, PC, Zhigh, Zlow, MDR, HI, LO, Y; all masked while fetching.
  assign sel   = busy ? '0 : {y_out, lo_out, hi_out, mdr_out, zlow_out, zhigh_out, pc_out, reg_out};
  assign multi = |(sel & (sel - NSRC'(1)));

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src_val[i] = regs_q[i];
    if (R0_ZERO) src_val[0] = '0;
    src_val[NUM_REGS]   = pc_q;
    src_val[NUM_REGS+1] = z_q[2*DATA_W-1:DATA_W];
    src_val[NUM_REGS+2] = z_q[DATA_W-1:0];
    src_val[NUM_REGS+3] = mdr_q;
    src_val[NUM_REGS+4] = hi_q;
    src_val[NUM_REGS+5] = lo_q;
    src_val[NUM_REGS+6] = y_q;
  end

  always_comb begin
    ext_bus = '0;
    for (int i = 0; i < NSRC; i++)
      if (sel[i]) ext_bus = ext_bus | src_val[i];
  end

  always_comb begin
    fetch_val = '0;
    case (state_q)
      S_T0:    fetch_val = pc_q;
      S_T1:    fetch_val = z_q[DATA_W-1:0];
      S_T2:    fetch_val = mdr_q;
      default: fetch_val = '0;
    endcase
  end

  assign bus = busy ? fetch_val : (multi ? '0 : ext_bus);

  // ALU: A = Y, B = bus. Sign-extending both operands makes the unsigned 2W product signed.
  assign add_w = {1'b0, y_q} + {1'b0, bus};
  assign sub_w = {1'b0, y_q} - {1'b0, bus};
  assign mul_w = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus[DATA_W-1]}}, bus};

  always_comb begin
    alu_z = '0;
    case (alu_op)
      3'd0: alu_z = {{(DATA_W-1){1'b0}}, add_w};
      3'd1: alu_z = {{(DATA_W-1){1'b0}}, sub_w};
      3'd2: alu_z[DATA_W-1:0] = y_q & bus;
      3'd3: alu_z[DATA_W-1:0] = y_q | bus;
      3'd4: alu_z = mul_w;
      3'd5: alu_z[DATA_W-1:0] = -bus;
      3'd6: alu_z[DATA_W-1:0] = ~bus;
      3'd7: alu_z[DATA_W-1:0] = bus;
      default: alu_z = '0;
    endcase
  end

  // Datapath next state: sequencer owns the transfers while busy, control unit otherwise.
  always_comb begin
    regs_d = regs_q;
    y_d    = y_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pc_d   = pc_q;
    mar_d  = mar_q;
    mdr_d  = mdr_q;
    ir_d   = ir_q;
    z_d    = z_q;
    case (state_q)
      S_T0: begin
        mar_d = pc_q;
        z_d   = {{DATA_W{1'b0}}, pc_q + ONE};
      end
      S_T1: begin
        if (t1_first_q) pc_d = z_q[DATA_W-1:0];
        if (mem_ack)    mdr_d = mem_rdata;
      end
      S_T2: ir_d = mdr_q;
      default: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (reg_in[i] && !(R0_ZERO && i == 0)) regs_d[i] = bus;
        if (y_in)  y_d  = bus;
        if (hi_in) hi_d = bus;
        if (lo_in) lo_d = bus;
        if (pc_in)       pc_d = bus;
        else if (inc_pc) pc_d = pc_q + ONE;
        if (mar_in) mar_d = bus;
        if (mdr_in) mdr_d = read ? mem_rdata : bus;
        if (ir_in)  ir_d  = bus;
        if (z_in)   z_d   = alu_z;
      end
    endcase
    sticky_d = sticky_q | bus_conflict;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      t1_first_q <= 1'b0;
      regs_q     <= '0;
      y_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pc_q       <= PC_RESET;
      mar_q      <= '0;
      mdr_q      <= '0;
      ir_q       <= '0;
      z_q        <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      t1_first_q <= t1_first_d;
      regs_q     <= regs_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      z_q        <= z_d;
      sticky_q   <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    t1_first_d = (state_q == S_T0);
    case (state_q)
      S_IDLE:  if (fetch_start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ack) state_d = S_T2;
      S_T2:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_busy = busy;
    fetch_done = (state_q == S_T2);
    mem_rd     = (state_q == S_T1) || (!busy && read && mdr_in);
  end

  assign mem_addr        = mar_q;
  assign ir_value        = ir_q;
  assign bus_value       = bus;
  assign bus_conflict    = !busy && multi;
  assign conflict_sticky = sticky_q;
endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed plus randomized bench for param_bus_datapath (DATA_W=32, 16 regs, R0_ZERO=1, PC_RESET=0x100).
module tb_param_bus_datapath;
  logic        clock, clear;
  logic [15:0] reg_in, reg_out;
  logic        pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, y_out;
  logic        pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, read;
  logic [2:0]  alu_op;
  logic        fetch_start, fetch_busy, fetch_done, mem_rd, mem_ack;
  logic [31:0] mem_addr, mem_rdata, ir_value, bus_value;
  logic        bus_conflict, conflict_sticky;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mr [16];

  param_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b1), .PC_RESET(32'h100)) dut (
    .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
    .pc_out(pc_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out), .mdr_out(mdr_out),
    .hi_out(hi_out), .lo_out(lo_out), .y_out(y_out),
    .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .read(read), .alu_op(alu_op),
    .fetch_start(fetch_start), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_value(ir_value), .bus_value(bus_value), .bus_conflict(bus_conflict),
    .conflict_sticky(conflict_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    reg_in = '0; reg_out = '0;
    {pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, y_out} = '0;
    {pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, read} = '0;
    alu_op = '0; fetch_start = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    idle_in(); read = 1; mdr_in = 1; mem_rdata = v; tick(); idle_in();
  endtask

  task automatic put_reg(input int k, input logic [31:0] v);
    mdr_load(v); mdr_out = 1; reg_in[k] = 1'b1; tick(); idle_in();
    mr[k] = (k == 0) ? 32'h0 : v;
  endtask

  task automatic peek_reg(input int k, output logic [31:0] v);
    reg_out = '0; reg_out[k] = 1'b1; #1; v = bus_value; reg_out = '0;
  endtask

  task automatic peek_pc(output logic [31:0] v);
    pc_out = 1; #1; v = bus_value; pc_out = 0;
  endtask

  task automatic set_y(input logic [31:0] v);
    mdr_load(v); mdr_out = 1; y_in = 1; tick(); idle_in();
  endtask

  task automatic run_alu(input logic [2:0] op, input logic [31:0] b);
    mdr_load(b); mdr_out = 1; alu_op = op; z_in = 1; tick(); idle_in();
  endtask

  task automatic read_z(output logic [63:0] z);
    zlow_out = 1; #1; z[31:0] = bus_value; zlow_out = 0;
    zhigh_out = 1; #1; z[63:32] = bus_value; zhigh_out = 0;
  endtask

  // Reference ALU written from the operation definitions with wide arithmetic.
  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: return 64'(a) + 64'(b);
      3'd1: return {31'b0, (a < b), 32'(a - b)};
      3'd2: return {32'b0, a & b};
      3'd3: return {32'b0, a | b};
      3'd4: return 64'(sa * sb);
      3'd5: return {32'b0, 32'(32'h0 - b)};
      3'd6: return {32'b0, ~b};
      default: return {32'b0, b};
    endcase
  endfunction

  initial begin
    logic [31:0] v, a, b;
    logic [63:0] z;
    logic [2:0]  op;
    int rd_cnt, done_cnt, k;

    idle_in();
    clear = 0;
    for (int i = 0; i < 16; i++) mr[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", fetch_busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_sticky", conflict_sticky, 0);
    chk("rst_ir", ir_value, 0);
    chk("rst_mar", mem_addr, 0);
    peek_pc(v); chk("rst_pc", v, 32'h100);
    clear = 1;
    tick();
    chk("bus_idle", bus_value, 0);
    chk("bus_conflict_idle", bus_conflict, 0);

    // ADD with carry out, then Zlow back into R7
    put_reg(3, 32'hFFFF_FFFF);
    put_reg(5, 32'h1);
    put_reg(7, 32'h1234);
    reg_out[3] = 1; y_in = 1; tick(); idle_in();
    reg_out[5] = 1; alu_op = 3'd0; z_in = 1; tick(); idle_in();
    read_z(z);
    chk("add_zlow", z[31:0], 32'h0);
    chk("add_zhigh", z[63:32], 32'h1);
    zlow_out = 1; reg_in[7] = 1; tick(); idle_in(); mr[7] = 32'h0;
    peek_reg(7, v); chk("r7_from_zlow", v, 32'h0);

    // signed multiply
    set_y(32'hFFFF_FFFD);
    run_alu(3'd4, 32'd7);
    read_z(z); chk("mul_neg3x7", z, 64'hFFFF_FFFF_FFFF_FFEB);

    // random register file traffic
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(8, 15);
      put_reg(k, $urandom);
    end
    put_reg(2, 32'hA5A5_0002);
    put_reg(4, 32'h5A5A_0004);
    for (int i = 0; i < 16; i++) begin
      peek_reg(i, v); chk($sformatf("rf_R%0d", i), v, mr[i]);
    end

    // bus conflict and sticky flag
    reg_out[2] = 1; reg_out[4] = 1; pc_out = 1; #1;
    chk("conf_bus", bus_value, 0);
    chk("conf_flag", bus_conflict, 1);
    chk("conf_sticky_pre", conflict_sticky, 0);
    tick(); idle_in(); #1;
    chk("conf_sticky_set", conflict_sticky, 1);
    chk("conf_flag_clear", bus_conflict, 0);
    tick();
    chk("conf_sticky_hold", conflict_sticky, 1);

    // R0 hard-wired to zero
    put_reg(0, 32'h55);
    peek_reg(0, v); chk("r0_zero", v, 32'h0);

    // autonomous fetch with a 4-cycle memory wait
    mdr_load(32'h40); mdr_out = 1; pc_in = 1; tick(); idle_in();
    fetch_start = 1; tick(); fetch_start = 0;
    chk("fetch_busy_t0", fetch_busy, 1);
    rd_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40 && fetch_busy; c++) begin
      reg_in = '1; reg_out = 16'h0014; pc_out = 1; y_in = 1;
      fetch_start = (c == 1);
      mem_rdata = 32'hDEAD_BEEF;
      mem_ack = 0;
      #1;
      if (c == 2) chk("fetch_conflict_masked", bus_conflict, 0);
      if (mem_rd) begin
        rd_cnt++;
        if (rd_cnt == 1) chk("fetch_mem_addr", mem_addr, 32'h40);
      end
      mem_ack = mem_rd && (rd_cnt == 4);
      if (fetch_done) done_cnt++;
      tick();
    end
    idle_in();
    chk("fetch_timeout", fetch_busy, 0);
    for (int c = 0; c < 4; c++) begin
      if (fetch_done || fetch_busy) done_cnt++;
      tick();
    end
    chk("fetch_rd_cycles", rd_cnt, 4);
    chk("fetch_done_pulses", done_cnt, 1);
    chk("fetch_ir", ir_value, 32'hDEAD_BEEF);
    peek_pc(v); chk("fetch_pc", v, 32'h41);
    peek_reg(3, v); chk("fetch_r3_kept", v, mr[3]);
    peek_reg(5, v); chk("fetch_r5_kept", v, mr[5]);

    // PC wrap and pc_in priority
    mdr_load(32'hFFFF_FFFF); mdr_out = 1; pc_in = 1; tick(); idle_in();
    inc_pc = 1; tick(); idle_in();
    peek_pc(v); chk("pc_wrap", v, 32'h0);
    mdr_load(32'h77); mdr_out = 1; pc_in = 1; inc_pc = 1; tick(); idle_in();
    peek_pc(v); chk("pc_in_priority", v, 32'h77);

    // randomized ALU against the reference model
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if (i < 8) begin op = 3'(i); a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      set_y(a);
      run_alu(op, b);
      read_z(z);
      chk($sformatf("alu_op%0d_%h_%h", op, a, b), z, ref_alu(op, a, b));
    end

    // asynchronous reset in the middle of a fetch
    fetch_start = 1; tick(); fetch_start = 0; tick(); tick();
    chk("abort_in_fetch", fetch_busy, 1);
    #2 clear = 0; #1;
    chk("abort_busy", fetch_busy, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_ir", ir_value, 0);
    chk("abort_sticky", conflict_sticky, 0);
    chk("abort_mar", mem_addr, 0);
    peek_pc(v); chk("abort_pc", v, 32'h100);
    tick(); clear = 1; tick();
    chk("post_reset_idle", fetch_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Next-generation single-bus CPU datapath, generalised in data width and register count.
- Contains the register file, Y, 2W-bit Z (Zhigh/Zlow), HI, LO, PC, MAR, MDR and IR around one shared bus.
- Adds an integrated ALU, bus-conflict detection and an autonomous instruction-fetch sequencer with a memory read handshake.
- Sits between the control unit (drives the enables) and the memory subsystem.

Parameters:
- DATA_W, 32, width of bus and all registers; Z is 2*DATA_W.
- NUM_REGS, 16, general registers R0..R(NUM_REGS-1); legal range 2..32.
- R0_ZERO, 0, when 1, R0 always reads as 0 and writes to R0 are discarded.
- PC_RESET, 0, PC value after reset.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- reg_in  in  NUM_REGS  one-hot write enables; bit i loads Ri from the bus.
- reg_out  in  NUM_REGS  bus source selects for R0..Rn.
- pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, y_out  in  1 each  further bus source selects.
- pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in  in  1 each  load enables.
- read  in  1  with mdr_in, MDR loads mem_rdata instead of the bus.
- alu_op  in  3  ALU operation.
- fetch_start  in  1  starts an autonomous fetch.
- fetch_busy  out  1  sequencer not IDLE.
- fetch_done  out  1  one-cycle pulse when IR is loaded.
- mem_addr  out  DATA_W  MAR contents.
- mem_rd  out  1  memory read request.
- mem_ack  in  1  memory data valid on mem_rdata.
- mem_rdata  in  DATA_W  memory read data.
- ir_value  out  DATA_W  IR contents.
- bus_value  out  DATA_W  current bus.
- bus_conflict  out  1  combinational: more than one source is selected.
- conflict_sticky  out  1  registered; set on any conflict cycle, cleared only by reset.

Behaviour:
- Reset (clear=0, asynchronous): all registers 0; PC=PC_RESET; sequencer in IDLE; mem_rd=0, fetch_done=0, conflict_sticky=0.
- Bus:
  - Exactly one select asserted: bus = that source.
  - No select asserted: bus = 0.
  - Two or more selects asserted: bus = 0 and bus_conflict=1; conflict_sticky sets at the next edge.
  - With R0_ZERO=1, R0 reads as 0.
- Loads: all register loads occur at the rising edge when the enable is high; loaded data is visible on the bus next cycle.
  - pc_in takes priority over inc_pc; inc_pc alone gives PC <= PC+1, wrapping modulo 2^DATA_W.
- ALU (z_in loads Z = {Zhigh,Zlow}); A=Y, B=bus:
  - 0 ADD: Zlow=A+B; Zhigh[0]=carry-out, rest of Zhigh 0.
  - 1 SUB: Zlow=A-B; Zhigh[0]=borrow, rest of Zhigh 0.
  - 2 AND, 3 OR: Zlow=A&B or A|B; Zhigh=0.
  - 4 MUL: signed full product, 2*DATA_W bits.
  - 5 NEG: Zlow=-B; Zhigh=0.
  - 6 NOT: Zlow=~B; Zhigh=0.
  - 7 PASSB: Zlow=B; Zhigh=0.
- Fetch sequencer states: IDLE, T0, T1, T2.
  - IDLE: fetch_start=1 -> T0. fetch_start asserted in any other state is ignored.
  - T0 (1 cycle): MAR <= PC; Z <= {0, PC+1} via an internal increment path, not the bus.
  - T1: PC <= Zlow on the first T1 cycle only. mem_rd=1 throughout T1. Stays in T1 until mem_ack=1; that edge loads MDR <= mem_rdata -> T2. There is no timeout.
  - T2 (1 cycle): IR <= MDR through the internal path; fetch_done=1 during T2 -> IDLE.
  - fetch_busy=1 in T0, T1 and T2.
- While fetch_busy=1:
  - All external load enables and bus selects are masked.
  - bus_value shows the sequencer's internal transfer value.
  - bus_conflict is forced to 0.
- Outside fetch, mem_rd = read & mdr_in.
- mem_ack while not in T1 has no effect except through the external read & mdr_in load.
- Reset during fetch: abort immediately to IDLE with reset values; no partial IR update.
- Minimum fetch latency: 3 cycles from the first T0 edge to the IR load when mem_ack arrives on the first T1 cycle.

Test Plan:
- Reset with PC_RESET=0x100, clear low mid-operation -> all registers 0, PC=0x100, mem_rd=0, fetch_busy=0 asynchronously.
- R3=0xFFFFFFFF into Y, R5=1 on bus, alu_op=ADD, z_in -> Zlow=0, Zhigh=1; Zlow to R7 -> R7=0.
- Y=-3, bus=7, alu_op=MUL -> Z=0xFFFFFFFF_FFFFFFEB.
- PC=0x40, fetch_start, mem_ack delayed 4 cycles, mem_rdata=0xDEADBEEF:
  - mem_addr=0x40; PC=0x41 after the first T1 cycle.
  - mem_rd high 4 cycles; IR=0xDEADBEEF; single fetch_done pulse.
  - External reg_in asserted during the fetch writes nothing.
- reg_out bits 2 and 4 plus pc_out together -> bus_value=0, bus_conflict=1, conflict_sticky=1 next cycle and remaining set; with R0_ZERO=1, R0 written 0x55 and read back -> 0.
- PC=0xFFFFFFFF, inc_pc -> PC=0; fetch_start while busy -> ignored, exactly one fetch_done pulse.
